addsub_seq_ctrl: RTL



---
 rtl/addsub_seq_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial two's-complement add/subtract controller: one 4-bit slice per clock,
// LSB nibble first, carry chained through a register, final sum/co/ovf registered on completion.
module addsub_seq_ctrl #(
   parameter int NIBBLES = 4,
   localparam int W = 4 * NIBBLES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         op_sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         co,
   output logic         ovf
);

   // state | meaning
   // IDLE  | waiting for start; operands sampled on the accepting edge
   // RUN   | one nibble processed per edge, counter selects the nibble
   // DONE  | one-cycle completion pulse, start ignored, returns to IDLE
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int CW = 3;
   localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);
   localparam logic [W-1:0]  NIB_MASK = {{(W-4){1'b0}}, 4'hF};

   state_t        state;
   logic [CW-1:0] cnt;
   logic          carry;
   logic          sub_q;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  work;

   logic [4:0]    sh;
   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic [3:0]    a_nib;
   logic [3:0]    b_nib;
   logic [4:0]    sum;
   logic [3:0]    low;
   logic          c3;
   logic          last;
   logic [W-1:0]  merged;

   always_comb begin
      sh     = {cnt, 2'b00};
      a_sh   = a_q >> sh;
      b_sh   = b_q >> sh;
      a_nib  = a_sh[3:0];
      b_nib  = b_sh[3:0] ^ {4{sub_q}};
      sum    = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
      // carry into the nibble's top bit, needed for signed overflow on the last nibble
      low    = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry};
      c3     = low[3];
      last   = (cnt == LAST_NIB);
      merged = (work & ~(NIB_MASK << sh)) | ({{(W-4){1'b0}}, sum[3:0]} << sh);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         carry  <= 1'b0;
         sub_q  <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         work   <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         co     <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q   <= a;
                  b_q   <= b;
                  sub_q <= op_sub;
                  carry <= op_sub;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               work  <= merged;
               carry <= sum[4];
               if (last) begin
                  cnt    <= '0;
                  result <= merged;
                  co     <= sum[4];
                  ovf    <= c3 ^ sum[4];
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
